threshold_monitor_8bits: RTL and testbench

- Sequential stage directly downstream of the 8-bit magnitude comparator.
- Consumes the comparator's gt/lt/eq flags for a stream of samples. The comparator's a input is the sample and its b input is the threshold.
- Applies debounce hysteresis and reports a filtered above-threshold level, one-cycle rise/fall pulses and a saturating crossing-event count.
- Feeds control logic that needs glitch-free threshold crossings.

---
 rtl/threshold_monitor_8bits_if.sv | 37 +++
 rtl/threshold_monitor_8bits.sv | 157 +++++++++++++++
 tb/tb_threshold_monitor_8bits.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/threshold_monitor_8bits_if.sv
// ---------------------------------------------------------------------------
// threshold_monitor_8bits_if
// Bundle between the magnitude-comparator stage and the threshold monitor.
//   master : drives the per-sample comparator flags and clear; observes results
//     in_valid  - gt/lt/eq carry a new sample result this cycle
//     gt/lt/eq  - comparator flags (sample vs threshold)
//     clear     - synchronous soft reset of the monitor
//   slave  : the monitor; drives the filtered results
//     above     - debounced level (1 = above threshold)
//     rise/fall - one-cycle transition pulses
//     event_cnt - saturating count of rise events
//     err       - sticky non-one-hot flag indication
// ---------------------------------------------------------------------------
interface threshold_monitor_8bits_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             gt;
  logic             lt;
  logic             eq;
  logic             clear;
  logic             above;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] event_cnt;
  logic             err;

  modport master (
    output in_valid, gt, lt, eq, clear,
    input  above, rise, fall, event_cnt, err
  );

  modport slave (
    input  in_valid, gt, lt, eq, clear,
    output above, rise, fall, event_cnt, err
  );
endinterface

// File: rtl/threshold_monitor_8bits.sv
// ---------------------------------------------------------------------------
// threshold_monitor_8bits
// Debounced threshold-crossing monitor fed by an 8-bit magnitude comparator.
// A level change needs DEBOUNCE consecutive qualifying accepted samples
// (gt to go HIGH, lt to go LOW); eq or the opposite flag aborts a pending run.
// Idle cycles (in_valid=0) do not break a run. All outputs are registered.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - threshold_monitor_8bits_if.slave (flags in, level/pulses/count out)
// Parameters:
//   DEBOUNCE - qualifying samples per level change, 1..15
//   CNT_W    - width of event_cnt
// ---------------------------------------------------------------------------
module threshold_monitor_8bits #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  threshold_monitor_8bits_if.slave    bus
);

  localparam logic [1:0] ST_LOW     = 2'd0;
  localparam logic [1:0] ST_PEND_HI = 2'd1;
  localparam logic [1:0] ST_HIGH    = 2'd2;
  localparam logic [1:0] ST_PEND_LO = 2'd3;

  localparam logic [3:0]       DEB     = 4'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic             above_q, above_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] flags;
  logic       one_hot;
  logic       accept;
  logic [3:0] run_inc;

  assign flags   = {bus.gt, bus.lt, bus.eq};
  assign one_hot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  assign accept  = bus.in_valid && one_hot;
  assign run_inc = run_q + 4'd1;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = cnt_q;
    // A valid but malformed flag set only raises err; state is left alone.
    err_d   = err_q || (bus.in_valid && !one_hot);

    if (accept) begin
      case (state_q)
        ST_LOW: begin
          if (bus.gt) begin
            if (DEB == 4'd1) begin
              state_d = ST_HIGH;
              rise_d  = 1'b1;
            end else begin
              state_d = ST_PEND_HI;
              run_d   = 4'd1;
            end
          end
        end
        ST_PEND_HI: begin
          if (bus.gt) begin
            if (run_inc == DEB) begin
              state_d = ST_HIGH;
              run_d   = 4'd0;
              rise_d  = 1'b1;
            end else begin
              run_d = run_inc;
            end
          end else begin
            state_d = ST_LOW;
            run_d   = 4'd0;
          end
        end
        ST_HIGH: begin
          if (bus.lt) begin
            if (DEB == 4'd1) begin
              state_d = ST_LOW;
              fall_d  = 1'b1;
            end else begin
              state_d = ST_PEND_LO;
              run_d   = 4'd1;
            end
          end
        end
        default: begin // ST_PEND_LO
          if (bus.lt) begin
            if (run_inc == DEB) begin
              state_d = ST_LOW;
              run_d   = 4'd0;
              fall_d  = 1'b1;
            end else begin
              run_d = run_inc;
            end
          end else begin
            state_d = ST_HIGH;
            run_d   = 4'd0;
          end
        end
      endcase
    end

    if (rise_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // clear wins over any simultaneous sample and cancels pending pulses.
    if (bus.clear) begin
      state_d = ST_LOW;
      run_d   = 4'd0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end

    above_d = (state_d == ST_HIGH) || (state_d == ST_PEND_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOW;
      run_q   <= 4'd0;
      above_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      above_q <= above_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.above     = above_q;
  assign bus.rise      = rise_q;
  assign bus.fall      = fall_q;
  assign bus.err       = err_q;
  assign bus.event_cnt = cnt_q;

endmodule

// File: tb/tb_threshold_monitor_8bits.sv
module tb_threshold_monitor_8bits;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  threshold_monitor_8bits_if #(.CNT_W(8)) bus_a ();
  threshold_monitor_8bits_if #(.CNT_W(2)) bus_b ();

  threshold_monitor_8bits #(.DEBOUNCE(4), .CNT_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  threshold_monitor_8bits #(.DEBOUNCE(1), .CNT_W(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic ab, input logic ri,
                       input logic fa, input int cnt, input logic er);
    check1({tag, ".above"}, bus_a.above, ab);
    check1({tag, ".rise"},  bus_a.rise,  ri);
    check1({tag, ".fall"},  bus_a.fall,  fa);
    checkn({tag, ".cnt"},   int'(bus_a.event_cnt), cnt);
    check1({tag, ".err"},   bus_a.err,   er);
  endtask

  task automatic chk_b(input string tag, input logic ab, input logic ri,
                       input logic fa, input int cnt, input logic er);
    check1({tag, ".above"}, bus_b.above, ab);
    check1({tag, ".rise"},  bus_b.rise,  ri);
    check1({tag, ".fall"},  bus_b.fall,  fa);
    checkn({tag, ".cnt"},   int'(bus_b.event_cnt), cnt);
    check1({tag, ".err"},   bus_b.err,   er);
  endtask

  // Drive one cycle of inputs (called at posedge+1), return at next posedge+1.
  task automatic cyc_a(input logic v, input logic g, input logic l,
                       input logic e, input logic c);
    bus_a.in_valid = v;
    bus_a.gt       = g;
    bus_a.lt       = l;
    bus_a.eq       = e;
    bus_a.clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input logic v, input logic g, input logic l,
                       input logic e, input logic c);
    bus_b.in_valid = v;
    bus_b.gt       = g;
    bus_b.lt       = l;
    bus_b.eq       = e;
    bus_b.clear    = c;
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, check it took effect at once, release at posedge+1.
  task automatic async_reset(input string tag);
    bus_a.in_valid = 1'b0; bus_a.gt = 1'b0; bus_a.lt = 1'b0; bus_a.eq = 1'b0; bus_a.clear = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.gt = 1'b0; bus_b.lt = 1'b0; bus_b.eq = 1'b0; bus_b.clear = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_a(tag, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.gt = 1'b0; bus_a.lt = 1'b0; bus_a.eq = 1'b0; bus_a.clear = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.gt = 1'b0; bus_b.lt = 1'b0; bus_b.eq = 1'b0; bus_b.clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset_a", 0, 0, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // 1: async reset while PEND_HI with run=2, then a full run of 4 is needed
    cyc_a(1, 1, 0, 0, 0); chk_a("t1_g1", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t1_g2", 0, 0, 0, 0, 0);
    async_reset("t1_async");
    cyc_a(1, 1, 0, 0, 0); chk_a("t1_r1", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t1_r2", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t1_r3", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t1_r4", 1, 1, 0, 1, 0);
    cyc_a(0, 0, 0, 0, 0); chk_a("t1_idle", 1, 0, 0, 1, 0);
    // reset while HIGH with a nonzero count
    async_reset("t1_async_high");

    // 2: four consecutive gt
    cyc_a(1, 1, 0, 0, 0); chk_a("t2_g1", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t2_g2", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t2_g3", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t2_g4", 1, 1, 0, 1, 0);
    cyc_a(0, 0, 0, 0, 0); chk_a("t2_idle", 1, 0, 0, 1, 0);
    cyc_a(0, 0, 0, 0, 1); chk_a("t2_clear", 0, 0, 0, 0, 0);

    // 3: gt,gt,gt,eq aborts; invalid gt does not count
    cyc_a(1, 1, 0, 0, 0); chk_a("t3_g1", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t3_g2", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t3_g3", 0, 0, 0, 0, 0);
    cyc_a(1, 0, 0, 1, 0); chk_a("t3_eq", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t3_h1", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t3_h2", 0, 0, 0, 0, 0);
    cyc_a(0, 1, 0, 0, 0); chk_a("t3_inv", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t3_h3", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t3_h4", 1, 1, 0, 1, 0);
    cyc_a(0, 0, 0, 0, 1); chk_a("t3_clear", 0, 0, 0, 0, 0);

    // 4: gapped run, then lt x4 for a fall
    cyc_a(1, 1, 0, 0, 0); chk_a("t4_g1", 0, 0, 0, 0, 0);
    cyc_a(0, 0, 0, 0, 0); chk_a("t4_gap1", 0, 0, 0, 0, 0);
    cyc_a(0, 0, 0, 0, 0); chk_a("t4_gap2", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t4_g2", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t4_g3", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t4_g4", 1, 1, 0, 1, 0);
    cyc_a(1, 0, 1, 0, 0); chk_a("t4_l1", 1, 0, 0, 1, 0);
    cyc_a(1, 0, 1, 0, 0); chk_a("t4_l2", 1, 0, 0, 1, 0);
    cyc_a(1, 0, 1, 0, 0); chk_a("t4_l3", 1, 0, 0, 1, 0);
    cyc_a(1, 0, 1, 0, 0); chk_a("t4_l4", 0, 0, 1, 1, 0);
    cyc_a(0, 0, 0, 0, 0); chk_a("t4_idle", 0, 0, 0, 1, 0);

    // 5: illegal sample mid-run leaves run intact; clear with gt discards it
    cyc_a(1, 1, 0, 0, 0); chk_a("t5_g1", 0, 0, 0, 1, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t5_g2", 0, 0, 0, 1, 0);
    cyc_a(1, 1, 1, 0, 0); chk_a("t5_bad", 0, 0, 0, 1, 1);
    cyc_a(1, 1, 0, 0, 0); chk_a("t5_g3", 0, 0, 0, 1, 1);
    cyc_a(1, 1, 0, 0, 0); chk_a("t5_g4", 1, 1, 0, 2, 1);
    cyc_a(1, 1, 0, 0, 1); chk_a("t5_clear", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t5_h1", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t5_h2", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t5_h3", 0, 0, 0, 0, 0);
    cyc_a(1, 1, 0, 0, 0); chk_a("t5_h4", 1, 1, 0, 1, 0);
    cyc_a(0, 0, 0, 0, 0); chk_a("t5_idle", 1, 0, 0, 1, 0);

    // 6: DEBOUNCE=1, CNT_W=2 saturation over 5 rises
    chk_b("t6_start", 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      int exp_cnt;
      exp_cnt = (k > 3) ? 3 : k;
      cyc_b(1, 1, 0, 0, 0); chk_b($sformatf("t6_rise%0d", k), 1, 1, 0, exp_cnt, 0);
      cyc_b(1, 0, 1, 0, 0); chk_b($sformatf("t6_fall%0d", k), 0, 0, 1, exp_cnt, 0);
    end
    cyc_b(0, 0, 0, 0, 0); chk_b("t6_idle", 0, 0, 0, 3, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
